// File: rtl/dual_port_mem_arbiter.sv
// rtl/dual_port_mem_arbiter.sv - round-robin A/B arbiter and sequencer for a 16x32 dual-port memory
module dual_port_mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              A_wr_req,
    input  logic [ADDR_W-1:0] A_wr_addr,
    input  logic [DATA_W-1:0] A_wr_data,
    output logic              A_wr_gnt,
    input  logic              B_wr_req,
    input  logic [ADDR_W-1:0] B_wr_addr,
    input  logic [DATA_W-1:0] B_wr_data,
    output logic              B_wr_gnt,
    input  logic              A_rd_req,
    input  logic [ADDR_W-1:0] A_rd_addr,
    output logic              A_rd_gnt,
    output logic              A_rd_valid,
    output logic [DATA_W-1:0] A_rd_data,
    input  logic              B_rd_req,
    input  logic [ADDR_W-1:0] B_rd_addr,
    output logic              B_rd_gnt,
    output logic              B_rd_valid,
    output logic [DATA_W-1:0] B_rd_data,
    output logic              Wr_en,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [DATA_W-1:0] Data_in,
    output logic              Rd_en,
    output logic [ADDR_W-1:0] Rd_addr,
    input  logic [DATA_W-1:0] Mem_rdata
);

    logic              wr_last_q, wr_last_d;
    logic              rd_last_q, rd_last_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              tag1_vld_q, tag1_vld_d;
    logic              tag1_id_q, tag1_id_d;
    logic              tag2_vld_q, tag2_vld_d;
    logic              tag2_id_q, tag2_id_d;
    logic              a_rd_valid_q, a_rd_valid_d;
    logic              b_rd_valid_q, b_rd_valid_d;
    logic [DATA_W-1:0] a_rd_data_q, a_rd_data_d;
    logic [DATA_W-1:0] b_rd_data_q, b_rd_data_d;

    logic              wr_pick_b, wr_go;
    logic [ADDR_W-1:0] wr_win_addr;
    logic              rd_pick_b, rd_any, rd_go, raw_hazard;
    logic [ADDR_W-1:0] rd_win_addr;

    always_comb begin
        // B wins a conflict only when A was the last one served
        wr_pick_b   = B_wr_req && (!A_wr_req || !wr_last_q);
        wr_go       = A_wr_req || B_wr_req;
        wr_win_addr = wr_pick_b ? B_wr_addr : A_wr_addr;

        rd_pick_b   = B_rd_req && (!A_rd_req || !rd_last_q);
        rd_any      = A_rd_req || B_rd_req;
        rd_win_addr = rd_pick_b ? B_rd_addr : A_rd_addr;

        // A read landing on the address being written now would see stale data; retry it
        raw_hazard  = rd_any && wr_go && (rd_win_addr == wr_win_addr);
        rd_go       = rd_any && !raw_hazard;

        A_wr_gnt = A_wr_req && !wr_pick_b;
        B_wr_gnt = wr_pick_b;
        A_rd_gnt = A_rd_req && !rd_pick_b && !raw_hazard;
        B_rd_gnt = rd_pick_b && !raw_hazard;
    end

    always_comb begin
        wr_en_d      = wr_go;
        wr_addr_d    = wr_go ? wr_win_addr : wr_addr_q;
        data_in_d    = wr_go ? (wr_pick_b ? B_wr_data : A_wr_data) : data_in_q;
        wr_last_d    = wr_go ? wr_pick_b : wr_last_q;

        rd_en_d      = rd_go;
        rd_addr_d    = rd_go ? rd_win_addr : rd_addr_q;
        rd_last_d    = rd_go ? rd_pick_b : rd_last_q;

        tag1_vld_d   = rd_go;
        tag1_id_d    = rd_go ? rd_pick_b : tag1_id_q;
        tag2_vld_d   = tag1_vld_q;
        tag2_id_d    = tag1_id_q;

        a_rd_valid_d = tag2_vld_q && !tag2_id_q;
        b_rd_valid_d = tag2_vld_q && tag2_id_q;
        a_rd_data_d  = a_rd_valid_d ? Mem_rdata : a_rd_data_q;
        b_rd_data_d  = b_rd_valid_d ? Mem_rdata : b_rd_data_q;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_last_q    <= 1'b1;
            rd_last_q    <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            data_in_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            tag1_vld_q   <= 1'b0;
            tag1_id_q    <= 1'b0;
            tag2_vld_q   <= 1'b0;
            tag2_id_q    <= 1'b0;
            a_rd_valid_q <= 1'b0;
            b_rd_valid_q <= 1'b0;
            a_rd_data_q  <= '0;
            b_rd_data_q  <= '0;
        end else begin
            wr_last_q    <= wr_last_d;
            rd_last_q    <= rd_last_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            data_in_q    <= data_in_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            tag1_vld_q   <= tag1_vld_d;
            tag1_id_q    <= tag1_id_d;
            tag2_vld_q   <= tag2_vld_d;
            tag2_id_q    <= tag2_id_d;
            a_rd_valid_q <= a_rd_valid_d;
            b_rd_valid_q <= b_rd_valid_d;
            a_rd_data_q  <= a_rd_data_d;
            b_rd_data_q  <= b_rd_data_d;
        end
    end

    assign Wr_en      = wr_en_q;
    assign Wr_addr    = wr_addr_q;
    assign Data_in    = data_in_q;
    assign Rd_en      = rd_en_q;
    assign Rd_addr    = rd_addr_q;
    assign A_rd_valid = a_rd_valid_q;
    assign B_rd_valid = b_rd_valid_q;
    assign A_rd_data  = a_rd_data_q;
    assign B_rd_data  = b_rd_data_q;

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// tb/tb_dual_port_mem_arbiter.sv - scoreboard bench for dual_port_mem_arbiter with a behavioural memory
module tb_dual_port_mem_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          A_wr_req, B_wr_req, A_rd_req, B_rd_req;
    logic [AW-1:0] A_wr_addr, B_wr_addr, A_rd_addr, B_rd_addr;
    logic [DW-1:0] A_wr_data, B_wr_data;
    logic          A_wr_gnt, B_wr_gnt, A_rd_gnt, B_rd_gnt;
    logic          A_rd_valid, B_rd_valid;
    logic [DW-1:0] A_rd_data, B_rd_data;
    logic          Wr_en, Rd_en;
    logic [AW-1:0] Wr_addr, Rd_addr;
    logic [DW-1:0] Data_in, Mem_rdata;

    always #5 Clk = ~Clk;

    dual_port_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Rst(Rst),
        .A_wr_req(A_wr_req), .A_wr_addr(A_wr_addr), .A_wr_data(A_wr_data), .A_wr_gnt(A_wr_gnt),
        .B_wr_req(B_wr_req), .B_wr_addr(B_wr_addr), .B_wr_data(B_wr_data), .B_wr_gnt(B_wr_gnt),
        .A_rd_req(A_rd_req), .A_rd_addr(A_rd_addr), .A_rd_gnt(A_rd_gnt),
        .A_rd_valid(A_rd_valid), .A_rd_data(A_rd_data),
        .B_rd_req(B_rd_req), .B_rd_addr(B_rd_addr), .B_rd_gnt(B_rd_gnt),
        .B_rd_valid(B_rd_valid), .B_rd_data(B_rd_data),
        .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Data_in(Data_in),
        .Rd_en(Rd_en), .Rd_addr(Rd_addr), .Mem_rdata(Mem_rdata)
    );

    // Memory: write commits and read data updates on the edge that samples the enables
    logic [DW-1:0] mem [16];
    always @(posedge Clk) begin
        if (Wr_en) mem[Wr_addr] <= Data_in;
        if (Rd_en) Mem_rdata <= mem[Rd_addr];
    end

    int            n_cmp = 0;
    int            n_err = 0;
    int            n_valid = 0;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] rd_exp [4];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_ctl"}, {20'd0, Wr_en, Rd_en, Wr_addr, Rd_addr, A_rd_valid, B_rd_valid}, '0);
        check({name, "_gnt"}, {28'd0, A_wr_gnt, B_wr_gnt, A_rd_gnt, B_rd_gnt}, '0);
        check({name, "_data_in"}, Data_in, '0);
        check({name, "_a_rd_data"}, A_rd_data, '0);
        check({name, "_b_rd_data"}, B_rd_data, '0);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pop_check(input logic tag, input logic [DW-1:0] data);
        logic [DW:0] e;
        n_valid++;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rd_valid: got tag %0d data %h, required no valid", tag, data);
        end else begin
            e = exp_q.pop_front();
            check1("rd_tag", tag, e[DW]);
            check("rd_data", data, e[DW-1:0]);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            if (A_rd_valid) pop_check(1'b0, A_rd_data);
            if (B_rd_valid) pop_check(1'b1, B_rd_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        int v;
        rd_exp[0] = 32'h0404_0404;
        rd_exp[1] = 32'h0505_0505;
        rd_exp[2] = 32'h0606_0606;
        rd_exp[3] = 32'h0707_0707;
        A_wr_req = 0; B_wr_req = 0; A_rd_req = 0; B_rd_req = 0;
        A_wr_addr = 0; B_wr_addr = 0; A_rd_addr = 0; B_rd_addr = 0;
        A_wr_data = 0; B_wr_data = 0;
        Rst = 1'b1;
        #1 Rst = 1'b0;
        #2 check_reset("reset_initial");
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b1;
        repeat (3) tick();
        check_reset("idle_after_release");

        // Single-requester write then read
        A_wr_req = 1; A_wr_addr = 4'd1; A_wr_data = 32'hAAAA_AAAA;
        @(negedge Clk);
        check1("single_a_wr_gnt", A_wr_gnt, 1'b1);
        check1("single_b_wr_gnt", B_wr_gnt, 1'b0);
        tick();
        A_wr_req = 0;
        check1("wr_en_pulse", Wr_en, 1'b1);
        check("wr_addr", {28'd0, Wr_addr}, 32'd1);
        check("data_in", Data_in, 32'hAAAA_AAAA);
        tick();
        check1("wr_en_drop", Wr_en, 1'b0);
        check("data_in_hold", Data_in, 32'hAAAA_AAAA);

        A_rd_req = 1; A_rd_addr = 4'd1;
        @(negedge Clk);
        check1("single_a_rd_gnt", A_rd_gnt, 1'b1);
        exp_q.push_back({1'b0, 32'hAAAA_AAAA});
        tick();
        A_rd_req = 0;
        check1("rd_en_pulse", Rd_en, 1'b1);
        check("rd_addr", {28'd0, Rd_addr}, 32'd1);
        tick();
        check1("rd_valid_not_early", A_rd_valid, 1'b0);
        tick();
        check1("rd_valid_latency", A_rd_valid, 1'b1);
        check1("b_rd_valid_quiet", B_rd_valid, 1'b0);
        tick();
        check1("rd_valid_one_cycle", A_rd_valid, 1'b0);

        // Asynchronous reset mid-run, away from any edge
        #2 Rst = 1'b0;
        #1 check_reset("async_reset_midrun");
        tick();
        Rst = 1'b1;
        tick();

        // Write contention: grants alternate starting with A
        A_wr_req = 1; A_wr_addr = 4'd2; A_wr_data = 32'h2222_0000;
        B_wr_req = 1; B_wr_addr = 4'd3; B_wr_data = 32'h3333_0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check1("wr_rr_a_gnt", A_wr_gnt, k % 2 == 0);
            check1("wr_rr_b_gnt", B_wr_gnt, k % 2 == 1);
            tick();
            if (k % 2 == 0) begin
                A_wr_data = 32'h2222_0001;
                if (k == 2) A_wr_req = 0;
            end else begin
                B_wr_data = 32'h3333_0001;
                if (k == 3) B_wr_req = 0;
            end
        end

        A_rd_req = 1; A_rd_addr = 4'd2; B_rd_req = 1; B_rd_addr = 4'd3;
        @(negedge Clk);
        check1("rd_first_a", A_rd_gnt, 1'b1);
        check1("rd_first_not_b", B_rd_gnt, 1'b0);
        exp_q.push_back({1'b0, 32'h2222_0001});
        tick();
        A_rd_req = 0;
        @(negedge Clk);
        check1("rd_second_b", B_rd_gnt, 1'b1);
        exp_q.push_back({1'b1, 32'h3333_0001});
        tick();
        B_rd_req = 0;
        repeat (3) tick();

        // Preload addresses 4..7 from A, one write per cycle
        A_wr_req = 1;
        for (int i = 0; i < 4; i++) begin
            A_wr_addr = 4'(4 + i);
            A_wr_data = rd_exp[i];
            @(negedge Clk);
            check1("preload_gnt", A_wr_gnt, 1'b1);
            tick();
        end
        A_wr_req = 0;

        // Read interleave: A reads 4,5 and B reads 6,7, back to back
        A_rd_req = 1; A_rd_addr = 4'd4; B_rd_req = 1; B_rd_addr = 4'd6;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check1("rd_rr_a_gnt", A_rd_gnt, k % 2 == 0);
            check1("rd_rr_b_gnt", B_rd_gnt, k % 2 == 1);
            case (k)
                0: exp_q.push_back({1'b0, 32'h0404_0404});
                1: exp_q.push_back({1'b1, 32'h0606_0606});
                2: exp_q.push_back({1'b0, 32'h0505_0505});
                default: exp_q.push_back({1'b1, 32'h0707_0707});
            endcase
            tick();
            case (k)
                0: A_rd_addr = 4'd5;
                1: B_rd_addr = 4'd7;
                2: A_rd_req = 0;
                default: B_rd_req = 0;
            endcase
        end
        repeat (4) tick();

        // RAW hazard: B writes addr 9 while A reads addr 9
        B_wr_req = 1; B_wr_addr = 4'd9; B_wr_data = 32'h1234_5678;
        A_rd_req = 1; A_rd_addr = 4'd9;
        @(negedge Clk);
        check1("raw_b_wr_gnt", B_wr_gnt, 1'b1);
        check1("raw_a_rd_stall", A_rd_gnt, 1'b0);
        check1("raw_b_rd_stall", B_rd_gnt, 1'b0);
        tick();
        B_wr_req = 0;
        @(negedge Clk);
        check1("raw_a_rd_retry", A_rd_gnt, 1'b1);
        exp_q.push_back({1'b0, 32'h1234_5678});
        tick();
        A_rd_req = 0;
        repeat (4) tick();

        // Reset with a read in flight: its result must never appear
        A_rd_req = 1; A_rd_addr = 4'd1;
        @(negedge Clk);
        check1("inflight_a_rd_gnt", A_rd_gnt, 1'b1);
        tick();
        A_rd_req = 0;
        v = n_valid;
        Rst = 1'b0;
        #1 check_reset("reset_inflight");
        repeat (2) tick();
        Rst = 1'b1;
        repeat (5) tick();
        check("no_valid_after_reset", n_valid, v);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
